// File: rtl/load_store_unit.sv
// Purpose : RV32I memory-access stage; turns ALU address + rs2 into one valid/ack bus access.
// Latency : request cycle -> REQ (one cycle per bus wait) -> DONE pulse; 2 busy cycles on a zero-wait bus.
// Backpressure: busy stalls the core until ack, an illegal-access fault, or a MAX_WAIT timeout.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   mem_read, mem_write     load/store request, held stable by the core while busy
//   funct3, addr, wdata     RV32I size/sign field, effective address, store data
//   rdata_out               formatted load result (held until the next successful load)
//   busy, done, fault       stall request, completion pulse, fault pulse (with done)
//   bus_req/we/addr/wdata/be/ack/rdata   word-addressed valid/ack data bus
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_out,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [1:0]  lat_off;   // byte offset of the access, used for load lane select
  logic [2:0]  lat_f3;

  logic        req_any;
  logic        legal;
  logic        f3_ok;
  logic        align_ok;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] load_fmt;

  assign req_any = mem_read | mem_write;

  // busy is the only combinational output: the core must stall in the
  // same cycle it presents the request.
  assign busy = ((state == IDLE) && req_any) || (state == REQ);

  // Legality, byte enables and lane-replicated store data for the request
  // currently presented in IDLE.
  always_comb begin
    f3_ok      = 1'b0;
    align_ok   = 1'b1;
    be_calc    = 4'b1111;
    wdata_calc = 32'h0;

    if (mem_read) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
        default:                                f3_ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
        default:                f3_ok = 1'b0;
      endcase
    end

    case (funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{wdata[7:0]}};
      end
      2'b01: begin
        align_ok   = ~addr[0];
        be_calc    = 4'b0011 << addr[1:0];
        wdata_calc = {2{wdata[15:0]}};
      end
      default: begin
        align_ok   = (addr[1:0] == 2'b00);
        be_calc    = 4'b1111;
        wdata_calc = wdata;
      end
    endcase

    if (!mem_write) begin
      wdata_calc = 32'h0;
    end
  end

  // Asserting both mem_read and mem_write is treated as an illegal access.
  assign legal = (mem_read ^ mem_write) && f3_ok && align_ok;

  // Load formatting from the latched offset/size; only consumed on ack.
  always_comb begin
    logic [31:0] shifted;
    logic [7:0]  lb;
    logic [15:0] lh;
    shifted  = bus_rdata >> {lat_off, 3'b000};
    lb       = shifted[7:0];
    lh       = lat_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    load_fmt = bus_rdata;
    case (lat_f3)
      3'b000:  load_fmt = {{24{lb[7]}}, lb};
      3'b001:  load_fmt = {{16{lh[15]}}, lh};
      3'b100:  load_fmt = {24'h0, lb};
      3'b101:  load_fmt = {16'h0, lh};
      default: load_fmt = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      lat_off   <= 2'b00;
      lat_f3    <= 3'b000;
      rdata_out <= 32'h0;
      done      <= 1'b0;
      fault     <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      bus_be    <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          done     <= 1'b0;
          fault    <= 1'b0;
          wait_cnt <= 8'd0;
          if (req_any) begin
            if (legal) begin
              lat_off   <= addr[1:0];
              lat_f3    <= funct3;
              bus_req   <= 1'b1;
              bus_we    <= mem_write;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_wdata <= wdata_calc;
              bus_be    <= be_calc;
              state     <= REQ;
            end else begin
              // Illegal accesses never touch the bus.
              done  <= 1'b1;
              fault <= 1'b1;
              state <= DONE;
            end
          end
        end

        REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            done    <= 1'b1;
            if (!bus_we) begin
              rdata_out <= load_fmt;
            end
            state <= DONE;
          end else if (wait_cnt + 8'd1 == WAIT_LIM) begin
            // This is the MAX_WAIT-th REQ cycle without ack: give up.
            bus_req <= 1'b0;
            done    <= 1'b1;
            fault   <= 1'b1;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          fault <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_out;
  logic        busy;
  logic        done;
  logic        fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int vectors = 0;
  int miscompares = 0;

  load_store_unit #(.MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata_out(rdata_out),
    .busy(busy), .done(done), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    funct3    = 3'b000;
    addr      = 32'h0;
    wdata     = 32'h0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if ({busy, done, fault, bus_req, bus_we} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 00000", {busy, done, fault, bus_req, bus_we});
    end
    vectors++;
    if ({rdata_out, bus_addr, bus_wdata, bus_be} !== 100'h0) begin
      miscompares++;
      $display("FAIL reset_data: rdata_out=%h bus_addr=%h bus_wdata=%h bus_be=%b want all 0",
               rdata_out, bus_addr, bus_wdata, bus_be);
    end
  endtask

  task automatic test_lw_zero_wait();
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h100;
    #1;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL lw_busy_c1: got %b want 1", busy); end
    tick();  // REQ
    vectors++;
    if ({bus_req, bus_we, bus_be, busy} !== 7'b1_0_1111_1 || bus_addr !== 32'h100 || bus_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL lw_req: req=%b we=%b be=%b busy=%b addr=%h wd=%h want 1 0 1111 1 00000100 00000000",
               bus_req, bus_we, bus_be, busy, bus_addr, bus_wdata);
    end
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    tick();  // DONE
    vectors++;
    if ({done, fault, busy, bus_req} !== 4'b1000 || rdata_out !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL lw_done: done=%b fault=%b busy=%b req=%b rdata=%h want 1 0 0 0 deadbeef",
               done, fault, busy, bus_req, rdata_out);
    end
    idle_inputs();
    tick();
    vectors++;
    if ({done, busy} !== 2'b00) begin miscompares++; $display("FAIL lw_after: done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3 [5]  = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000};
    logic [31:0] ad [5]  = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101};
    logic [3:0]  ebe [5] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0010};
    logic [31:0] erd [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00008011, 32'hFFFF8011, 32'h00000022};
    for (int i = 0; i < 5; i++) begin
      mem_read = 1'b1; funct3 = f3[i]; addr = ad[i];
      tick();
      vectors++;
      if (bus_req !== 1'b1 || bus_be !== ebe[i] || bus_addr !== 32'h100) begin
        miscompares++;
        $display("FAIL ld_be[%0d]: req=%b be=%b addr=%h want 1 %b 00000100", i, bus_req, bus_be, bus_addr, ebe[i]);
      end
      bus_ack = 1'b1; bus_rdata = 32'h80112233;
      tick();
      vectors++;
      if (done !== 1'b1 || fault !== 1'b0 || rdata_out !== erd[i]) begin
        miscompares++;
        $display("FAIL ld_rdata[%0d]: done=%b fault=%b rdata=%h want 1 0 %h", i, done, fault, rdata_out, erd[i]);
      end
      idle_inputs();
      tick();
    end
  endtask

  task automatic test_sh_wait();
    mem_write = 1'b1; funct3 = 3'b001; addr = 32'h202; wdata = 32'h1234ABCD;
    tick();
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if ({bus_req, bus_we, bus_be, busy, done} !== 8'b1_1_1100_1_0 || bus_addr !== 32'h200 ||
          bus_wdata !== 32'hABCDABCD) begin
        miscompares++;
        $display("FAIL sh_req[%0d]: req=%b we=%b be=%b busy=%b done=%b addr=%h wd=%h want 1 1 1100 1 0 00000200 abcdabcd",
                 c, bus_req, bus_we, bus_be, busy, done, bus_addr, bus_wdata);
      end
      bus_ack = (c == 3);
      tick();
    end
    vectors++;
    if ({done, fault, busy, bus_req} !== 4'b1000 || rdata_out !== 32'h00000022) begin
      miscompares++;
      $display("FAIL sh_done: done=%b fault=%b busy=%b req=%b rdata=%h want 1 0 0 0 00000022",
               done, fault, busy, bus_req, rdata_out);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_illegal();
    logic        rd [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        wr [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3 [6] = '{3'b010, 3'b001, 3'b001, 3'b011, 3'b100, 3'b010};
    logic [31:0] ad [6] = '{32'h101, 32'h001, 32'h103, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      mem_read = rd[i]; mem_write = wr[i]; funct3 = f3[i]; addr = ad[i]; wdata = 32'h55AA55AA;
      #1;
      vectors++;
      if (busy !== 1'b1 || bus_req !== 1'b0) begin
        miscompares++;
        $display("FAIL ill_req[%0d]: busy=%b req=%b want 1 0", i, busy, bus_req);
      end
      tick();
      vectors++;
      if ({done, fault, busy, bus_req} !== 4'b1100 || rdata_out !== 32'h00000022) begin
        miscompares++;
        $display("FAIL ill_done[%0d]: done=%b fault=%b busy=%b req=%b rdata=%h want 1 1 0 0 00000022",
                 i, done, fault, busy, bus_req, rdata_out);
      end
      idle_inputs();
      tick();
      vectors++;
      if ({done, fault, bus_req} !== 3'b000) begin
        miscompares++;
        $display("FAIL ill_after[%0d]: done=%b fault=%b req=%b want 0 0 0", i, done, fault, bus_req);
      end
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    bit seen_done = 1'b0;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300; bus_rdata = 32'h12345678;
    tick();
    for (int i = 0; i < 40 && !seen_done; i++) begin
      if (done) begin
        seen_done = 1'b1;
      end else begin
        if (bus_req) req_cycles++;
        tick();
      end
    end
    vectors++;
    if (!seen_done) begin
      miscompares++;
      $display("FAIL to_done: no done within 40 cycles, want done after 15");
    end
    vectors++;
    if (req_cycles !== 15) begin
      miscompares++;
      $display("FAIL to_req_cycles: got %0d want 15", req_cycles);
    end
    vectors++;
    if ({done, fault, bus_req, busy} !== 4'b1100 || rdata_out !== 32'h00000022) begin
      miscompares++;
      $display("FAIL to_fault: done=%b fault=%b req=%b busy=%b rdata=%h want 1 1 0 0 00000022",
               done, fault, bus_req, busy, rdata_out);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_req();
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400;
    tick();  // REQ cycle 1
    tick();  // REQ cycle 2
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_read = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h11111111;  // late ack, must be ignored
    #1;
    vectors++;
    if ({bus_req, done, fault, busy, bus_be} !== 8'b0) begin
      miscompares++;
      $display("FAIL rst_mid: req=%b done=%b fault=%b busy=%b be=%b want all 0", bus_req, done, fault, busy, bus_be);
    end
    tick();
    vectors++;
    if ({bus_req, done} !== 2'b00 || rdata_out !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_late_ack: req=%b done=%b rdata=%h want 0 0 00000000", bus_req, done, rdata_out);
    end
    bus_ack = 1'b0;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400;
    tick();
    vectors++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h400) begin
      miscompares++;
      $display("FAIL rst_next_req: req=%b addr=%h want 1 00000400", bus_req, bus_addr);
    end
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    tick();
    vectors++;
    if ({done, fault} !== 2'b10 || rdata_out !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL rst_next_done: done=%b fault=%b rdata=%h want 1 0 cafef00d", done, fault, rdata_out);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_lw_zero_wait();
    test_load_extend();
    test_sh_wait();
    test_illegal();
    test_timeout();
    test_reset_mid_req();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
